// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the program counter, addresses imem, registers
// the returned word toward decode with a valid/ready handshake, follows branch
// redirects, traps misaligned or out-of-range fetches, and counts deliveries.
module fetch_unit #(
    parameter int N       = 64,
    parameter int IMEM_AW = 6
) (
    input  logic               clk,
    input  logic               reset,
    output logic [IMEM_AW-1:0] imem_addr,
    input  logic [31:0]        imem_q,
    input  logic               out_ready,
    input  logic               branch_taken,
    input  logic [N-1:0]       branch_target,
    output logic               out_valid,
    output logic [31:0]        instr_out,
    output logic [N-1:0]       pc_out,
    output logic               fault,
    output logic [31:0]        fetch_count
);

    // First byte address past the fetchable window (4 * 2^IMEM_AW).
    localparam logic [N-1:0] LIMIT   = {{(N-IMEM_AW-3){1'b0}}, 1'b1, {(IMEM_AW+2){1'b0}}};
    localparam logic [N-1:0] PC_STEP = {{(N-3){1'b0}}, 3'b100};

    typedef enum logic [0:0] {
        ST_RUN   = 1'b0,
        ST_FAULT = 1'b1
    } state_t;

    state_t      state_q, state_d;
    logic [N-1:0] pc_q, pc_d;
    logic        out_valid_q, out_valid_d;
    logic [31:0] instr_q, instr_d;
    logic [N-1:0] pc_out_q, pc_out_d;
    logic        fault_q, fault_d;
    logic [31:0] count_q, count_d;

    logic        adv_s;
    logic        handshake_s;
    logic        bad_target_s;

    // Handshake qualifiers and redirect legality, shared by the next-state logic.
    always_comb begin
        adv_s        = !out_valid_q || out_ready;
        handshake_s  = out_valid_q && out_ready;
        bad_target_s = (branch_target[1:0] != 2'b00) || (branch_target >= LIMIT);
    end

    // Delivered-instruction counter: counts handshakes in RUN, sticks at all-ones.
    always_comb begin
        if ((state_q == ST_RUN) && handshake_s && (count_q != 32'hFFFF_FFFF)) begin
            count_d = count_q + 32'd1;
        end else begin
            count_d = count_q;
        end
    end

    // Fetch state machine: redirect, end-of-window trap, load or stall.
    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        out_valid_d = out_valid_q;
        instr_d     = instr_q;
        pc_out_d    = pc_out_q;
        fault_d     = fault_q;
        case (state_q)
            ST_RUN: begin
                if (branch_taken) begin
                    // The word currently being fetched is wrong-path: never loaded.
                    out_valid_d = 1'b0;
                    if (bad_target_s) begin
                        state_d = ST_FAULT;
                        fault_d = 1'b1;
                    end else begin
                        pc_d = branch_target;
                    end
                end else if (pc_q >= LIMIT) begin
                    // Only reachable by stepping past the last word.
                    state_d     = ST_FAULT;
                    fault_d     = 1'b1;
                    out_valid_d = 1'b0;
                end else if (adv_s) begin
                    instr_d     = imem_q;
                    pc_out_d    = pc_q;
                    out_valid_d = 1'b1;
                    pc_d        = pc_q + PC_STEP;
                end else begin
                    // Stall: decode holds the current word, everything keeps its value.
                    pc_d        = pc_q;
                    out_valid_d = out_valid_q;
                end
            end
            ST_FAULT: begin
                out_valid_d = 1'b0;
                fault_d     = 1'b1;
            end
            default: begin
                state_d     = ST_FAULT;
                out_valid_d = 1'b0;
                fault_d     = 1'b1;
            end
        endcase
    end

    // State register with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q     <= ST_RUN;
            pc_q        <= {N{1'b0}};
            out_valid_q <= 1'b0;
            instr_q     <= 32'h0000_0000;
            pc_out_q    <= {N{1'b0}};
            fault_q     <= 1'b0;
            count_q     <= 32'h0000_0000;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            out_valid_q <= out_valid_d;
            instr_q     <= instr_d;
            pc_out_q    <= pc_out_d;
            fault_q     <= fault_d;
            count_q     <= count_d;
        end
    end

    assign imem_addr   = pc_q[IMEM_AW+1:2];
    assign out_valid   = out_valid_q;
    assign instr_out   = instr_q;
    assign pc_out      = pc_out_q;
    assign fault       = fault_q;
    assign fetch_count = count_q;

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction-fetch stage that sits directly upstream of imem.
- Holds the program counter and drives imem's word address.
- Captures the returned instruction word into an output register, with a valid/ready handshake toward decode.
- Handles branch redirects and out-of-range or misaligned fetch faults, and counts delivered instructions.

Parameters:
N, 64, width of PC and branch target (bits)
IMEM_AW, 6, imem word-address width; fetchable range is 0 .. 4*2^IMEM_AW - 1 bytes

Ports:
clk  input  1  clock; all state updates on rising edge
reset  input  1  synchronous, active-low reset (asserted when 0)
imem_addr  output  IMEM_AW  word address to imem, = pc[IMEM_AW+1:2] (combinational from pc register)
imem_q  input  32  instruction word from imem (combinational, same cycle)
out_ready  input  1  decode accepts instr_out this cycle
branch_taken  input  1  redirect request from downstream
branch_target  input  N  byte address of redirect
out_valid  output  1  instr_out/pc_out hold a valid instruction
instr_out  output  32  registered instruction word
pc_out  output  N  byte address of instr_out
fault  output  1  sticky fetch fault
fetch_count  output  32  number of handshakes completed (out_valid && out_ready), saturating at 32'hFFFFFFFF

Behaviour:
- Reset is sampled only on a rising edge with reset==0, and applies mid-operation as well. It sets:
  - pc=0, state=RUN
  - out_valid=0, instr_out=0, pc_out=0
  - fault=0, fetch_count=0
- Consequently imem_addr=0 during and after reset.
- State machine has two states, RUN and FAULT. FAULT is left only by reset.
- Definitions used below:
  - LIMIT = 4*2^IMEM_AW (256 at the default).
  - adv = !out_valid || out_ready (output register may be loaded).
- RUN, evaluated in priority order each cycle:
  1. branch_taken=1, regardless of adv or out_ready:
     - If branch_target[1:0]!=0 or branch_target>=LIMIT: go to FAULT.
     - Else: pc<=branch_target and out_valid<=0, giving exactly one bubble cycle. The wrong-path instruction is discarded even if out_ready=1 that cycle.
     - fetch_count still increments if out_valid&&out_ready that cycle.
  2. pc>=LIMIT: go to FAULT. This is reachable only by sequential increment past the last word.
  3. adv=1:
     - instr_out<=imem_q, pc_out<=pc, out_valid<=1, pc<=pc+4.
     - pc+4 is computed N-bit unsigned. pc+4==LIMIT is legal to store and faults on the next cycle.
  4. adv=0 (stall): pc, instr_out, pc_out and out_valid hold.
- Latency:
  - First instruction (pc 0) is valid on the first edge after reset is released.
  - After a redirect, the target instruction is valid 2 edges after the branch_taken edge.
  - Unstalled throughput is one instruction per cycle.
- FAULT state:
  - fault=1 from the edge of entry onward; out_valid<=0 on entry.
  - pc, instr_out and pc_out hold their last values; branch_taken and out_ready are ignored.
  - fetch_count still counts a handshake that completes on the entry edge, then freezes.
- The out_valid, instr_out and pc_out handshake obeys these rules:
  - Once out_valid=1, instr_out and pc_out are stable until accepted or flushed.
  - out_valid never drops without a handshake except on branch flush, fault entry or reset.
- fetch_count increments on every edge with out_valid&&out_ready in RUN, and saturates without wrapping.

Test Plan:
1. Program load per the imem contents (word0=f8000001, word1=f8008002, word9=8b040064), reset released, out_ready=1 constantly → cycle 1: out_valid=1, instr_out=f8000001, pc_out=0. Cycle 2: instr_out=f8008002, pc_out=4. fetch_count=2 after cycle 2.
2. Stall: out_ready=0 for 3 cycles while instr_out=f8008002 → instr_out, pc_out=4 and imem_addr=2 are held. Release → next instr_out=f8000203, pc_out=8, and fetch_count does not count stalled cycles.
3. Branch_taken=1 with branch_target=0x24 while out_ready=0 → next cycle out_valid=0. The following cycle instr_out=8b040064, pc_out=0x24.
4. Faults:
   - branch_target=0x22 → fault=1 and out_valid=0 next cycle. Later branch_taken=1 with target 0 has no effect.
   - Separately, run with out_ready=1 from pc 0xFC → pc_out=0xFC is delivered, then fault=1.
5. Reset mid-operation: reset=0 for one edge while out_valid=1, fault=0, fetch_count=5 → out_valid=0, fetch_count=0, imem_addr=0. Next cycle after release: instr_out=f8000001.
6. Simultaneous branch_taken=1 and out_ready=1 with out_valid=1 → fetch_count increments by 1, the wrong-path word is dropped, and the target word appears 2 edges later.
